// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//   Collapsing issue queue and oldest-ready scheduler for the single ALU.
//   Dispatched ops wait here until both source physical registers have been
//   written back. Each cycle at most one op is issued (oldest ready first)
//   through a registered exeparam bundle to the ALU.
//
// Parameters
//   DW   width of the exeparam bundle (opaque to this block)
//   DP   queue depth in entries (DP >= 2)
//   RW   physical register index width; wbLog carries one bit per register
//
// Ports
//   CLK                 in   clock, rising edge
//   RSTn                in   asynchronous reset, active-low
//   flush               in   kills every queued entry and any issue this cycle
//   dispat_vaild        in   dispatch request
//   dispat_param        in   exeparam bundle to store
//   dispat_rs1/2        in   physical source register indices
//   dispat_ready        out  queue can accept an op (count < DP)
//   wbLog               in   bit i set: physical register i is written back
//   alu_exeparam_vaild  out  registered issue valid
//   alu_exeparam        out  registered issue bundle (holds when idle)
//   iq_count            out  occupied entries (debug / perf)
//
// Handshake: a dispatch transfers on a rising edge where dispat_vaild and
// dispat_ready are both high and flush is low. dispat_ready depends only on
// registered state, never on dispat_vaild. The ALU side has no ready: every
// cycle with alu_exeparam_vaild high is one op consumed.
// ---------------------------------------------------------------------------
module alu_issue #(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int RW = 6
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 flush,
  input  logic                 dispat_vaild,
  input  logic [DW-1:0]        dispat_param,
  input  logic [RW-1:0]        dispat_rs1,
  input  logic [RW-1:0]        dispat_rs2,
  output logic                 dispat_ready,
  input  logic [(2**RW)-1:0]   wbLog,
  output logic                 alu_exeparam_vaild,
  output logic [DW-1:0]        alu_exeparam,
  output logic [$clog2(DP):0]  iq_count
);

  localparam int SW = $clog2(DP);
  localparam int CW = SW + 1;

  // Entry storage, slot 0 is the oldest.
  logic [DW-1:0] ent_param [DP];
  logic [RW-1:0] ent_rs1   [DP];
  logic [RW-1:0] ent_rs2   [DP];
  logic [DP-1:0] ent_valid;
  logic [CW-1:0] count;

  logic [DW-1:0] param_nxt [DP];
  logic [RW-1:0] rs1_nxt   [DP];
  logic [RW-1:0] rs2_nxt   [DP];
  logic [DP-1:0] valid_nxt;
  logic [CW-1:0] count_nxt;

  logic [DP-1:0] ent_rdy;
  logic          sel_found;
  logic [SW-1:0] sel_idx;
  logic          issue;
  logic          accept;
  logic [CW-1:0] wr_slot;
  logic [SW-1:0] wr_idx;

  assign dispat_ready = (count < CW'(DP));
  assign iq_count     = count;
  assign issue        = sel_found & ~flush;
  assign accept       = dispat_vaild & dispat_ready & ~flush;
  // Append lands after compaction, so the slot drops by one when issuing.
  assign wr_slot      = count - {{(CW-1){1'b0}}, issue};
  assign wr_idx       = wr_slot[SW-1:0];

  // Physical register 0 is hardwired and always counts as written back.
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      ent_rdy[i] = ent_valid[i]
                 & ((ent_rs1[i] == '0) | wbLog[ent_rs1[i]])
                 & ((ent_rs2[i] == '0) | wbLog[ent_rs2[i]]);
    end
  end

  // Oldest-ready pick: scan from the top so the lowest index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DP-1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = i[SW-1:0];
      end
    end
  end

  always_comb begin
    param_nxt = ent_param;
    rs1_nxt   = ent_rs1;
    rs2_nxt   = ent_rs2;
    valid_nxt = ent_valid;
    count_nxt = count;
    if (flush) begin
      valid_nxt = '0;
      count_nxt = '0;
    end else begin
      if (issue) begin
        // Collapse: every slot at or above the issued one takes its upper neighbour.
        for (int i = 0; i < DP-1; i++) begin
          if (i >= int'(sel_idx)) begin
            param_nxt[i] = ent_param[i+1];
            rs1_nxt[i]   = ent_rs1[i+1];
            rs2_nxt[i]   = ent_rs2[i+1];
            valid_nxt[i] = ent_valid[i+1];
          end
        end
        valid_nxt[DP-1] = 1'b0;
      end
      if (accept) begin
        param_nxt[wr_idx] = dispat_param;
        rs1_nxt[wr_idx]   = dispat_rs1;
        rs2_nxt[wr_idx]   = dispat_rs2;
        valid_nxt[wr_idx] = 1'b1;
      end
      case ({accept, issue})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DP; i++) begin
        ent_param[i] <= '0;
        ent_rs1[i]   <= '0;
        ent_rs2[i]   <= '0;
      end
      ent_valid <= '0;
      count     <= '0;
    end else begin
      ent_param <= param_nxt;
      ent_rs1   <= rs1_nxt;
      ent_rs2   <= rs2_nxt;
      ent_valid <= valid_nxt;
      count     <= count_nxt;
    end
  end

  // Issue register; the bundle holds its last value when nothing issues.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      alu_exeparam_vaild <= 1'b0;
      alu_exeparam       <= '0;
    end else begin
      alu_exeparam_vaild <= issue;
      if (issue) begin
        alu_exeparam <= ent_param[sel_idx];
      end
    end
  end

  // Count is unsigned, so an underflow wraps above DP and trips this too.
  a_count_range: assert property (@(posedge CLK) disable iff (!RSTn) (count <= CW'(DP)));

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//   Directed bench for alu_issue. A queue-based reference model tracks the
//   expected queue contents and issue register; one compare process checks
//   the DUT against it every falling edge. Hand-computed issue orders go into
//   exp_q, and literal checks after selected edges pin the model.
// ---------------------------------------------------------------------------
module tb_alu_issue;

  localparam int DW  = 32;
  localparam int DP  = 4;
  localparam int RW  = 6;
  localparam int NPR = 2**RW;
  localparam int CW  = $clog2(DP) + 1;

  // Clock / reset / DUT signals
  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            flush = 1'b0;
  logic            dispat_vaild = 1'b0;
  logic [DW-1:0]   dispat_param = '0;
  logic [RW-1:0]   dispat_rs1 = '0;
  logic [RW-1:0]   dispat_rs2 = '0;
  logic            dispat_ready;
  logic [NPR-1:0]  wbLog = '0;
  logic            alu_exeparam_vaild;
  logic [DW-1:0]   alu_exeparam;
  logic [CW-1:0]   iq_count;

  always #5 CLK = ~CLK;

  alu_issue #(.DW(DW), .DP(DP), .RW(RW)) dut (
    .CLK                (CLK),
    .RSTn               (RSTn),
    .flush              (flush),
    .dispat_vaild       (dispat_vaild),
    .dispat_param       (dispat_param),
    .dispat_rs1         (dispat_rs1),
    .dispat_rs2         (dispat_rs2),
    .dispat_ready       (dispat_ready),
    .wbLog              (wbLog),
    .alu_exeparam_vaild (alu_exeparam_vaild),
    .alu_exeparam       (alu_exeparam),
    .iq_count           (iq_count)
  );

  // Reference model state
  typedef struct {
    logic [DW-1:0] param;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } op_t;

  op_t           mq[$];
  logic          m_vaild = 1'b0;
  logic [DW-1:0] m_param = '0;
  logic [DW-1:0] exp_q[$];

  int tests = 0;
  int fails = 0;

  function automatic bit op_ready(op_t o);
    return ((o.rs1 == '0) || wbLog[o.rs1]) && ((o.rs2 == '0) || wbLog[o.rs2]);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Model: queue in age order; on each edge pick the oldest ready op, then
  // append an accepted dispatch (acceptance judged on the pre-edge size).
  int  m_sel;
  bit  m_full;
  op_t m_new;
  initial begin
    forever begin
      @(posedge CLK or negedge RSTn);
      if (!RSTn) begin
        mq.delete();
        m_vaild = 1'b0;
        m_param = '0;
      end else if (flush) begin
        mq.delete();
        m_vaild = 1'b0;
      end else begin
        m_full = (mq.size() >= DP);
        m_sel  = -1;
        for (int i = 0; i < mq.size(); i++) begin
          if (m_sel < 0 && op_ready(mq[i])) m_sel = i;
        end
        if (m_sel >= 0) begin
          m_vaild = 1'b1;
          m_param = mq[m_sel].param;
          mq.delete(m_sel);
        end else begin
          m_vaild = 1'b0;
        end
        if (dispat_vaild && !m_full) begin
          m_new.param = dispat_param;
          m_new.rs1   = dispat_rs1;
          m_new.rs2   = dispat_rs2;
          mq.push_back(m_new);
        end
      end
    end
  end

  // Compare process: every falling edge, DUT against model and expected order.
  initial begin
    forever begin
      @(negedge CLK);
      chk("vaild", DW'(alu_exeparam_vaild), DW'(m_vaild));
      chk("param", alu_exeparam, m_param);
      chk("count", DW'(iq_count), DW'(mq.size()));
      chk("dispat_ready", DW'(dispat_ready), DW'(mq.size() < DP));
      if (RSTn && alu_exeparam_vaild === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_order: got unexpected issue %0h, want none", alu_exeparam);
        end else begin
          chk("issue_order", alu_exeparam, exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic dispatch(input logic [DW-1:0] p, input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    dispat_vaild = 1'b1;
    dispat_param = p;
    dispat_rs1   = r1;
    dispat_rs2   = r2;
    tick();
    dispat_vaild = 1'b0;
  endtask

  initial begin
    // Reset
    RSTn = 1'b0;
    repeat (2) tick();
    RSTn = 1'b1;
    tick();

    // 1: reset mid-operation with three waiting entries
    dispatch(32'h20, 6'd20, 6'd0);
    dispatch(32'h21, 6'd21, 6'd0);
    dispatch(32'h22, 6'd22, 6'd0);
    chk("t1_count_pre", DW'(iq_count), 32'd3);
    #2;
    RSTn = 1'b0;
    #1;
    chk("t1_rst_vaild", DW'(alu_exeparam_vaild), 32'd0);
    chk("t1_rst_count", DW'(iq_count), 32'd0);
    chk("t1_rst_ready", DW'(dispat_ready), 32'd1);
    tick();
    RSTn = 1'b1;
    tick();

    // 2: single op, rs1 written back, issues two edges after dispatch
    wbLog[5] = 1'b1;
    exp_q.push_back(32'h11);
    dispatch(32'h11, 6'd5, 6'd0);
    chk("t2_count_q", DW'(iq_count), 32'd1);
    tick();
    chk("t2_vaild", DW'(alu_exeparam_vaild), 32'd1);
    chk("t2_param", alu_exeparam, 32'h11);
    chk("t2_count", DW'(iq_count), 32'd0);
    tick();
    chk("t2_idle", DW'(alu_exeparam_vaild), 32'd0);
    wbLog = '0;

    // 3: younger ready op overtakes older waiting op
    exp_q.push_back(32'hB2);
    exp_q.push_back(32'hA1);
    dispatch(32'hA1, 6'd7, 6'd0);
    dispatch(32'hB2, 6'd0, 6'd0);
    tick();
    chk("t3_b_param", alu_exeparam, 32'hB2);
    chk("t3_b_count", DW'(iq_count), 32'd1);
    wbLog[7] = 1'b1;
    tick();
    chk("t3_a_param", alu_exeparam, 32'hA1);
    chk("t3_a_vaild", DW'(alu_exeparam_vaild), 32'd1);
    tick();
    wbLog = '0;

    // 4: three ops woken together issue oldest-first with no bubble
    exp_q.push_back(32'hC1);
    exp_q.push_back(32'hC2);
    exp_q.push_back(32'hC3);
    dispatch(32'hC1, 6'd9, 6'd0);
    dispatch(32'hC2, 6'd0, 6'd9);
    dispatch(32'hC3, 6'd9, 6'd9);
    wbLog[9] = 1'b1;
    tick();
    chk("t4_c1", alu_exeparam, 32'hC1);
    tick();
    chk("t4_c2", alu_exeparam, 32'hC2);
    chk("t4_c2_vaild", DW'(alu_exeparam_vaild), 32'd1);
    tick();
    chk("t4_c3", alu_exeparam, 32'hC3);
    chk("t4_c3_count", DW'(iq_count), 32'd0);
    tick();
    chk("t4_idle", DW'(alu_exeparam_vaild), 32'd0);
    wbLog = '0;

    // 5: full queue refuses dispatch, also on the cycle an entry issues
    dispatch(32'hE0, 6'd10, 6'd0);
    dispatch(32'hE1, 6'd11, 6'd0);
    dispatch(32'hE2, 6'd12, 6'd0);
    dispatch(32'hE3, 6'd13, 6'd0);
    chk("t5_full_count", DW'(iq_count), 32'd4);
    chk("t5_full_ready", DW'(dispat_ready), 32'd0);
    dispat_vaild = 1'b1;
    dispat_param = 32'hEE;
    dispat_rs1   = 6'd0;
    dispat_rs2   = 6'd0;
    tick();
    chk("t5_reject_count", DW'(iq_count), 32'd4);
    chk("t5_reject_vaild", DW'(alu_exeparam_vaild), 32'd0);
    dispat_param = 32'hEF;
    wbLog[12] = 1'b1;
    exp_q.push_back(32'hE2);
    tick();
    dispat_vaild = 1'b0;
    chk("t5_e2", alu_exeparam, 32'hE2);
    chk("t5_e2_count", DW'(iq_count), 32'd3);
    wbLog[10] = 1'b1;
    wbLog[11] = 1'b1;
    wbLog[13] = 1'b1;
    exp_q.push_back(32'hE0);
    exp_q.push_back(32'hE1);
    exp_q.push_back(32'hE3);
    tick();
    chk("t5_e0", alu_exeparam, 32'hE0);
    tick();
    chk("t5_e1", alu_exeparam, 32'hE1);
    tick();
    chk("t5_e3", alu_exeparam, 32'hE3);
    chk("t5_empty", DW'(iq_count), 32'd0);
    tick();
    wbLog = '0;

    // 6: flush with a pending issue and a simultaneous dispatch
    dispatch(32'hD1, 6'd14, 6'd0);
    dispatch(32'hD2, 6'd15, 6'd0);
    wbLog[14]    = 1'b1;
    flush        = 1'b1;
    dispat_vaild = 1'b1;
    dispat_param = 32'hD3;
    dispat_rs1   = 6'd0;
    dispat_rs2   = 6'd0;
    tick();
    flush        = 1'b0;
    dispat_vaild = 1'b0;
    chk("t6_vaild", DW'(alu_exeparam_vaild), 32'd0);
    chk("t6_count", DW'(iq_count), 32'd0);
    chk("t6_ready", DW'(dispat_ready), 32'd1);
    repeat (3) tick();
    chk("t6_no_late_issue", DW'(alu_exeparam_vaild), 32'd0);
    wbLog = '0;

    chk("exp_q_drained", DW'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
